// File: rtl/axil_rd_arbiter_if.sv
// Bundle of every bus signal around the AXI4-lite read arbiter.
//   s_axil_*  requester side, S_COUNT ports packed into flat vectors
//             (port i address at [i*ADDR_WIDTH +: ADDR_WIDTH], prot at [i*3 +: 3])
//   m_axil_*  single forwarded read master port toward the target
// Modports:
//   slave   the arbiter's view (takes requests, drives forwarded AR and returned R)
//   master  the environment's view (requesters plus target)
interface axil_rd_arbiter_if #(
    parameter int S_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr;
    logic [S_COUNT*3-1:0]          s_axil_arprot;
    logic [S_COUNT-1:0]            s_axil_arvalid;
    logic [S_COUNT-1:0]            s_axil_arready;
    logic [DATA_WIDTH-1:0]         s_axil_rdata;
    logic [1:0]                    s_axil_rresp;
    logic [S_COUNT-1:0]            s_axil_rvalid;
    logic [S_COUNT-1:0]            s_axil_rready;

    logic [ADDR_WIDTH-1:0]         m_axil_araddr;
    logic [2:0]                    m_axil_arprot;
    logic                          m_axil_arvalid;
    logic                          m_axil_arready;
    logic [DATA_WIDTH-1:0]         m_axil_rdata;
    logic [1:0]                    m_axil_rresp;
    logic                          m_axil_rvalid;
    logic                          m_axil_rready;

    modport slave (
        input  s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
               m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
               m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready
    );

    modport master (
        output s_axil_araddr, s_axil_arprot, s_axil_arvalid, s_axil_rready,
               m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
               m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready
    );
endinterface

// File: rtl/axil_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4-lite read master among S_COUNT
// requesters. One transaction in flight; every output is a flop.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  axil_rd_arbiter_if.slave: s_axil_* requester ports, m_axil_* target port
module axil_rd_arbiter #(
    parameter int S_COUNT    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    axil_rd_arbiter_if.slave  bus
);
    localparam int GW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    typedef enum logic [2:0] {IDLE, ACCEPT, ADDR, DATA, RESP} state_t;

    state_t                state, state_n;
    logic [GW-1:0]         grant, grant_n;
    logic [GW-1:0]         last, last_n;
    logic [S_COUNT-1:0]    arready, arready_n;
    logic [S_COUNT-1:0]    rvalid, rvalid_n;
    logic [DATA_WIDTH-1:0] rdata, rdata_n;
    logic [1:0]            rresp, rresp_n;
    logic [ADDR_WIDTH-1:0] araddr, araddr_n;
    logic [2:0]            arprot, arprot_n;
    logic                  arvalid, arvalid_n;
    logic                  rready, rready_n;

    // Unpack the flat per-port request fields so they can be indexed by grant.
    logic [ADDR_WIDTH-1:0] req_addr [S_COUNT];
    logic [2:0]            req_prot [S_COUNT];
    for (genvar g = 0; g < S_COUNT; g++) begin : g_unpack
        assign req_addr[g] = bus.s_axil_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_prot[g] = bus.s_axil_arprot[g*3 +: 3];
    end

    // Round-robin search: first requester at or after last+1, wrapping.
    logic          req_found;
    logic [GW-1:0] req_idx;
    logic [GW-1:0] cand;
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= S_COUNT; i++) begin
            cand = GW'((int'(last) + i) % S_COUNT);
            if (!req_found && bus.s_axil_arvalid[cand]) begin
                req_found = 1'b1;
                req_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant   <= '0;
            last    <= GW'(S_COUNT - 1);
            arready <= '0;
            rvalid  <= '0;
            rdata   <= '0;
            rresp   <= '0;
            araddr  <= '0;
            arprot  <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
        end else begin
            state   <= state_n;
            grant   <= grant_n;
            last    <= last_n;
            arready <= arready_n;
            rvalid  <= rvalid_n;
            rdata   <= rdata_n;
            rresp   <= rresp_n;
            araddr  <= araddr_n;
            arprot  <= arprot_n;
            arvalid <= arvalid_n;
            rready  <= rready_n;
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        last_n    = last;
        arready_n = '0;           // arready is a single-cycle pulse
        rvalid_n  = rvalid;
        rdata_n   = rdata;
        rresp_n   = rresp;
        araddr_n  = araddr;
        arprot_n  = arprot;
        arvalid_n = arvalid;
        rready_n  = rready;
        case (state)
            IDLE: begin
                if (req_found && rvalid == '0) begin
                    grant_n            = req_idx;
                    last_n             = req_idx;
                    arready_n[req_idx] = 1'b1;
                    state_n            = ACCEPT;
                end
            end
            ACCEPT: begin
                // A requester that dropped arvalid before its ready pulse is
                // simply abandoned.
                if (bus.s_axil_arvalid[grant]) begin
                    araddr_n  = req_addr[grant];
                    arprot_n  = req_prot[grant];
                    arvalid_n = 1'b1;
                    state_n   = ADDR;
                end else begin
                    state_n = IDLE;
                end
            end
            ADDR: begin
                if (bus.m_axil_arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (bus.m_axil_rvalid) begin
                    rdata_n         = bus.m_axil_rdata;
                    rresp_n         = bus.m_axil_rresp;
                    rready_n        = 1'b0;
                    rvalid_n[grant] = 1'b1;
                    state_n         = RESP;
                end
            end
            RESP: begin
                if (bus.s_axil_rready[grant]) begin
                    rvalid_n = '0;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.s_axil_arready = arready;
    assign bus.s_axil_rvalid  = rvalid;
    assign bus.s_axil_rdata   = rdata;
    assign bus.s_axil_rresp   = rresp;
    assign bus.m_axil_araddr  = araddr;
    assign bus.m_axil_arprot  = arprot;
    assign bus.m_axil_arvalid = arvalid;
    assign bus.m_axil_rready  = rready;
endmodule

// File: tb/tb_axil_rd_arbiter.sv
// Directed bench for axil_rd_arbiter: behavioural requesters on all ports,
// a behavioural target with programmable wait states, and a protocol monitor.
module tb_axil_rd_arbiter;
    localparam int N = 4;

    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    axil_rd_arbiter_if #(.S_COUNT(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_rd_arbiter #(.S_COUNT(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks;
    int failures;
    int cyc;
    int viol;

    int req_cnt   [N];
    int t_ar      [N];
    int rwait_cnt [N];
    int ar_pulses [N];
    int r_beats   [N];
    logic [31:0] base [N];

    int rready_wait;
    int ar_wait;
    int r_wait;
    logic        tgt_fixed;
    logic [31:0] tgt_data;
    logic [1:0]  tgt_resp;
    logic [31:0] taddr;
    logic [2:0]  tprot;

    int          g_port [$];
    int          g_cyc  [$];
    int          b_port [$];
    int          b_cyc  [$];
    logic [31:0] b_data [$];
    logic [1:0]  b_resp [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (b_port.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (b_port.size() < n) chk(tag, 64'(b_port.size()), 64'(n));
    endtask

    // Requesters plus monitor; acts #1 after each rising edge. Handshakes are
    // logged in the cycle they are presented, i.e. before the edge completing them.
    initial begin
        logic        pv_marv;
        logic [31:0] pv_addr;
        logic [N-1:0] pv_rv;
        logic [31:0] pv_rdata;
        logic [1:0]  pv_rresp;
        bus.s_axil_arvalid = '0;
        bus.s_axil_rready  = '0;
        bus.s_axil_araddr  = '0;
        bus.s_axil_arprot  = '0;
        pv_marv = 1'b0; pv_addr = '0; pv_rv = '0; pv_rdata = '0; pv_rresp = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                bus.s_axil_arvalid = '0;
                bus.s_axil_rready  = '0;
                pv_marv = 1'b0;
                pv_rv   = '0;
                for (int i = 0; i < N; i++) rwait_cnt[i] = 0;
                continue;
            end
            if ($countones(bus.s_axil_arready) > 1) viol++;
            if ($countones(bus.s_axil_rvalid) > 1) viol++;
            if (bus.m_axil_arvalid && bus.m_axil_rready) viol++;
            if (bus.s_axil_arready != '0 && bus.s_axil_rvalid != '0) viol++;
            if (pv_marv && bus.m_axil_arvalid && bus.m_axil_araddr != pv_addr) viol++;
            if (pv_rv != '0 && bus.s_axil_rvalid == pv_rv &&
                (bus.s_axil_rdata != pv_rdata || bus.s_axil_rresp != pv_rresp)) viol++;
            pv_marv  = bus.m_axil_arvalid;
            pv_addr  = bus.m_axil_araddr;
            pv_rv    = bus.s_axil_rvalid;
            pv_rdata = bus.s_axil_rdata;
            pv_rresp = bus.s_axil_rresp;
            for (int i = 0; i < N; i++) begin
                if (bus.s_axil_arready[i]) ar_pulses[i]++;
                if (req_cnt[i] > 0 && !bus.s_axil_arvalid[i]) t_ar[i] = cyc;
                bus.s_axil_arvalid[i]        = (req_cnt[i] > 0);
                bus.s_axil_araddr[i*32 +: 32] = base[i];
                bus.s_axil_arprot[i*3 +: 3]   = 3'(i);
                if (bus.s_axil_rvalid[i]) begin
                    if (rwait_cnt[i] >= rready_wait) bus.s_axil_rready[i] = 1'b1;
                    else begin
                        bus.s_axil_rready[i] = 1'b0;
                        rwait_cnt[i]++;
                    end
                end else begin
                    bus.s_axil_rready[i] = 1'b0;
                    rwait_cnt[i] = 0;
                end
                if (bus.s_axil_arvalid[i] && bus.s_axil_arready[i]) begin
                    g_port.push_back(i);
                    g_cyc.push_back(cyc);
                    req_cnt[i]--;
                end
                if (bus.s_axil_rvalid[i] && bus.s_axil_rready[i]) begin
                    b_port.push_back(i);
                    b_cyc.push_back(cyc);
                    b_data.push_back(bus.s_axil_rdata);
                    b_resp.push_back(bus.s_axil_rresp);
                    r_beats[i]++;
                end
            end
        end
    end

    // Target: m_arready after ar_wait cycles of m_arvalid, m_rvalid r_wait
    // cycles after the AR handshake. Data echoes the address unless tgt_fixed.
    initial begin
        int tph;
        int tcnt;
        tph = 0;
        tcnt = 0;
        bus.m_axil_arready = 1'b0;
        bus.m_axil_rvalid  = 1'b0;
        bus.m_axil_rdata   = '0;
        bus.m_axil_rresp   = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                tph = 0; tcnt = 0;
                bus.m_axil_arready = 1'b0;
                bus.m_axil_rvalid  = 1'b0;
                continue;
            end
            if (tph == 4) begin
                bus.m_axil_rvalid = 1'b0;
                tph = 0; tcnt = 0;
            end
            if (tph == 1) begin
                bus.m_axil_arready = 1'b0;
                tcnt = 0;
                tph = 2;
            end else if (tph == 0) begin
                if (bus.m_axil_arvalid) begin
                    if (tcnt >= ar_wait) begin
                        bus.m_axil_arready = 1'b1;
                        taddr = bus.m_axil_araddr;
                        tprot = bus.m_axil_arprot;
                        tph = 1;
                    end else tcnt++;
                end else tcnt = 0;
            end
            if (tph == 2) begin
                if (tcnt >= r_wait) begin
                    bus.m_axil_rvalid = 1'b1;
                    bus.m_axil_rdata  = tgt_fixed ? tgt_data : taddr;
                    bus.m_axil_rresp  = tgt_resp;
                    tph = bus.m_axil_rready ? 4 : 3;
                end else tcnt++;
            end else if (tph == 3) begin
                if (bus.m_axil_rready) tph = 4;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int g0;
        int b0;
        int k;
        logic seen;
        checks = 0; failures = 0; cyc = 0; viol = 0;
        rready_wait = 0; ar_wait = 0; r_wait = 0;
        tgt_fixed = 1'b0; tgt_data = '0; tgt_resp = '0;
        taddr = '0; tprot = '0;
        for (int i = 0; i < N; i++) begin
            req_cnt[i] = 0; t_ar[i] = 0; rwait_cnt[i] = 0;
            ar_pulses[i] = 0; r_beats[i] = 0;
            base[i] = 32'h100 * (i + 1);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_arready", 64'(bus.s_axil_arready), 0);
        chk("rst_rvalid",  64'(bus.s_axil_rvalid), 0);
        chk("rst_marvalid", 64'(bus.m_axil_arvalid), 0);
        chk("rst_mrready", 64'(bus.m_axil_rready), 0);
        chk("rst_maraddr", 64'(bus.m_axil_araddr), 0);
        chk("rst_rdata",   64'(bus.s_axil_rdata), 0);
        rst = 1'b0;

        // 1: single read on port 2, zero-wait target
        base[2] = 32'h10;
        tgt_fixed = 1'b1; tgt_data = 32'hDEAD_BEEF; tgt_resp = 2'b00;
        @(negedge clk);
        g0 = g_port.size(); b0 = b_port.size();
        req_cnt[2] = 1;
        wait_beats("t1_timeout", b0 + 1, 50);
        chk("t1_maraddr", 64'(taddr), 64'h10);
        chk("t1_marprot", 64'(tprot), 64'h2);
        chk("t1_port",    64'(b_port[b0]), 2);
        chk("t1_data",    64'(b_data[b0]), 64'hDEAD_BEEF);
        chk("t1_resp",    64'(b_resp[b0]), 0);
        chk("t1_lat_ar",  64'(g_cyc[g0] - t_ar[2]), 1);
        chk("t1_lat_r",   64'(b_cyc[b0] - t_ar[2]), 4);
        base[2] = 32'h300;
        tgt_fixed = 1'b0;

        // 2: all four ports at once right after reset
        do_reset(2);
        @(negedge clk);
        g0 = g_port.size(); b0 = b_port.size();
        for (int i = 0; i < N; i++) begin
            ar_pulses[i] = 0; r_beats[i] = 0;
        end
        for (int i = 0; i < N; i++) req_cnt[i] = 1;
        wait_beats("t2_timeout", b0 + 4, 200);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("t2_grant%0d", i), 64'(g_port[g0+i]), 64'(i));
            chk($sformatf("t2_bport%0d", i), 64'(b_port[b0+i]), 64'(i));
            chk($sformatf("t2_data%0d", i),  64'(b_data[b0+i]), 64'(base[i]));
            chk($sformatf("t2_pulse%0d", i), 64'(ar_pulses[i]), 1);
            chk($sformatf("t2_beats%0d", i), 64'(r_beats[i]), 1);
        end

        // 3: ports 0 and 3 request continuously
        @(negedge clk);
        g0 = g_port.size(); b0 = b_port.size();
        req_cnt[0] = 4; req_cnt[3] = 4;
        wait_beats("t3_timeout", b0 + 8, 400);
        for (int i = 0; i < 8; i++)
            chk($sformatf("t3_grant%0d", i), 64'(g_port[g0+i]), (i % 2 == 1) ? 64'd3 : 64'd0);

        // 4: backpressure on both target and requester
        ar_wait = 5; r_wait = 7; rready_wait = 4;
        @(negedge clk);
        g0 = g_port.size(); b0 = b_port.size();
        req_cnt[1] = 1; req_cnt[2] = 1;
        wait_beats("t4_timeout", b0 + 2, 300);
        chk("t4_grant0", 64'(g_port[g0]), 1);
        chk("t4_grant1", 64'(g_port[g0+1]), 2);
        chk("t4_data",   64'(b_data[b0]), 64'(base[1]));
        chk("t4_lat",    64'(b_cyc[b0] - t_ar[1]), 20);
        chk("t4_nogrant", 64'(g_cyc[g0+1] > b_cyc[b0]), 1);
        chk("t4_data1",  64'(b_data[b0+1]), 64'(base[2]));
        ar_wait = 0; r_wait = 0; rready_wait = 0;

        // 5: error response passes through, then a normal read
        tgt_fixed = 1'b1; tgt_data = 32'h0BAD_0BAD; tgt_resp = 2'b10;
        @(negedge clk);
        b0 = b_port.size();
        req_cnt[3] = 1;
        wait_beats("t5_timeout", b0 + 1, 50);
        chk("t5_port", 64'(b_port[b0]), 3);
        chk("t5_resp", 64'(b_resp[b0]), 2);
        chk("t5_data", 64'(b_data[b0]), 64'h0BAD_0BAD);
        tgt_fixed = 1'b0; tgt_resp = 2'b00;
        @(negedge clk);
        req_cnt[0] = 1;
        wait_beats("t5b_timeout", b0 + 2, 50);
        chk("t5b_port", 64'(b_port[b0+1]), 0);
        chk("t5b_data", 64'(b_data[b0+1]), 64'(base[0]));
        chk("t5b_resp", 64'(b_resp[b0+1]), 0);

        // 6: reset while waiting for read data
        r_wait = 20;
        @(negedge clk);
        req_cnt[0] = 1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 50) begin
            @(negedge clk);
            seen = bus.m_axil_rready;
            k++;
        end
        chk("t6_in_data", 64'(seen), 1);
        b0 = b_port.size();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_arready", 64'(bus.s_axil_arready), 0);
        chk("t6_rvalid",  64'(bus.s_axil_rvalid), 0);
        chk("t6_marvalid", 64'(bus.m_axil_arvalid), 0);
        chk("t6_mrready", 64'(bus.m_axil_rready), 0);
        rst = 1'b0;
        r_wait = 0;
        repeat (4) @(negedge clk);
        chk("t6_nobeat", 64'(b_port.size()), 64'(b0));
        g0 = g_port.size();
        req_cnt[0] = 1; req_cnt[2] = 1;
        wait_beats("t6_timeout", b0 + 2, 100);
        chk("t6_grant0", 64'(g_port[g0]), 0);
        chk("t6_grant1", 64'(g_port[g0+1]), 2);

        repeat (3) @(negedge clk);
        chk("invariants", 64'(viol), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
